// File: rtl/pipeline_stall_controller_pkg.sv
// Shared pipeline control definitions: stall-FSM state encoding, the per-register
// freeze/bubble/flush bundle and the canned control patterns built from it.
package pipeline_stall_controller_pkg;

  localparam int DEFAULT_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_freeze;
    logic if_id_freeze;
    logic id_exe_bubble;
    logic id_exe_freeze;
    logic exe_mem_freeze;
    logic mem_wb_bubble;
    logic if_id_flush;
    logic id_exe_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '{default: 1'b0};

  // Whole front end held, MEM/WB fed a NOP: used for memory stalls and the fatal state
  localparam ctrl_t CTRL_MEM_HOLD = '{
    pc_freeze: 1'b1, if_id_freeze: 1'b1, id_exe_bubble: 1'b0, id_exe_freeze: 1'b1,
    exe_mem_freeze: 1'b1, mem_wb_bubble: 1'b1, if_id_flush: 1'b0, id_exe_flush: 1'b0
  };

  localparam ctrl_t CTRL_HAZARD = '{
    pc_freeze: 1'b1, if_id_freeze: 1'b1, id_exe_bubble: 1'b1, id_exe_freeze: 1'b0,
    exe_mem_freeze: 1'b0, mem_wb_bubble: 1'b0, if_id_flush: 1'b0, id_exe_flush: 1'b0
  };

  localparam ctrl_t CTRL_BRANCH = '{
    pc_freeze: 1'b0, if_id_freeze: 1'b0, id_exe_bubble: 1'b0, id_exe_freeze: 1'b0,
    exe_mem_freeze: 1'b0, mem_wb_bubble: 1'b0, if_id_flush: 1'b1, id_exe_flush: 1'b1
  };

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Count state: holds at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {WIDTH{1'b0}};
    end else if (clear) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc && (count_r != {WIDTH{1'b1}})) begin
      count_r <= count_r + WIDTH'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: memory-wait FSM with watchdog, Mealy decode of the
// per-register pipeline controls, and saturating stall/flush performance counters.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazard_detected,
  input  logic                 branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  input  logic                 cnt_clear,
  output logic                 pc_freeze,
  output logic                 if_id_freeze,
  output logic                 id_exe_bubble,
  output logic                 id_exe_freeze,
  output logic                 exe_mem_freeze,
  output logic                 mem_wb_bubble,
  output logic                 if_id_flush,
  output logic                 id_exe_flush,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e            state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              mem_timeout_r;
  logic              mem_stall_s;
  logic              timeout_hit_s;
  ctrl_t             ctrl_s;

  assign mem_stall_s = mem_req & ~mem_ready;

  // The current stalled cycle is the MEM_TIMEOUT-th consecutive one (counter holds the earlier ones)
  assign timeout_hit_s = (MEM_TIMEOUT != 0) &&
                         ((32'(wait_cnt_r) + 32'd1) >= 32'(MEM_TIMEOUT));

  // Memory-wait FSM, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mem_stall_s) begin
            state_r    <= ST_MEM_WAIT;
            wait_cnt_r <= WAIT_W'(1'b1);
          end else begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_stall_s) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
          end else if (timeout_hit_s) begin
            state_r       <= ST_ERROR;
            wait_cnt_r    <= {WAIT_W{1'b0}};
            mem_timeout_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1'b1);
          end
        end
        ST_ERROR: begin
          state_r       <= ST_ERROR;
          mem_timeout_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_RUN;
          wait_cnt_r <= {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // Mealy control decode: memory stall beats branch, branch beats hazard; all quiet in reset
  always_comb begin
    ctrl_s = CTRL_NONE;
    if (rst) begin
      ctrl_s = CTRL_NONE;
    end else begin
      case (state_r)
        ST_ERROR: ctrl_s = CTRL_MEM_HOLD;
        ST_RUN, ST_MEM_WAIT: begin
          if (mem_stall_s) begin
            ctrl_s = CTRL_MEM_HOLD;
          end else if (branch_taken) begin
            ctrl_s = CTRL_BRANCH;
          end else if (hazard_detected) begin
            ctrl_s = CTRL_HAZARD;
          end else begin
            ctrl_s = CTRL_NONE;
          end
        end
        default: ctrl_s = CTRL_NONE;
      endcase
    end
  end

  assign pc_freeze      = ctrl_s.pc_freeze;
  assign if_id_freeze   = ctrl_s.if_id_freeze;
  assign id_exe_bubble  = ctrl_s.id_exe_bubble;
  assign id_exe_freeze  = ctrl_s.id_exe_freeze;
  assign exe_mem_freeze = ctrl_s.exe_mem_freeze;
  assign mem_wb_bubble  = ctrl_s.mem_wb_bubble;
  assign if_id_flush    = ctrl_s.if_id_flush;
  assign id_exe_flush   = ctrl_s.id_exe_flush;
  assign mem_timeout    = mem_timeout_r;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl_s.pc_freeze),
    .clear (cnt_clear),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl_s.if_id_flush),
    .clear (cnt_clear),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller (MEM_TIMEOUT=4, CNT_WIDTH=4).
module tb_pipeline_stall_controller;
  import pipeline_stall_controller_pkg::*;

  localparam int TO   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard_detected = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic cnt_clear = 1'b0;
  logic pc_freeze, if_id_freeze, id_exe_bubble, id_exe_freeze, exe_mem_freeze;
  logic mem_wb_bubble, if_id_flush, id_exe_flush, mem_timeout;
  logic [CW-1:0] stall_count, flush_count;

  int total = 0;
  int bad   = 0;

  pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clear(cnt_clear),
    .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze), .id_exe_bubble(id_exe_bubble),
    .id_exe_freeze(id_exe_freeze), .exe_mem_freeze(exe_mem_freeze),
    .mem_wb_bubble(mem_wb_bubble), .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
    .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: fatal flag, consecutive stalled-memory cycles, plain integer counters
  bit m_error = 1'b0;
  int m_consec = 0;
  int m_stall = 0;
  int m_flush = 0;
  ctrl_t exp_c;

  always_comb begin
    exp_c = ctrl_t'(8'd0);
    if (!rst) begin
      if (m_error || (mem_req && !mem_ready)) begin
        exp_c.pc_freeze = 1'b1; exp_c.if_id_freeze = 1'b1; exp_c.id_exe_freeze = 1'b1;
        exp_c.exe_mem_freeze = 1'b1; exp_c.mem_wb_bubble = 1'b1;
      end else if (branch_taken) begin
        exp_c.if_id_flush = 1'b1; exp_c.id_exe_flush = 1'b1;
      end else if (hazard_detected) begin
        exp_c.pc_freeze = 1'b1; exp_c.if_id_freeze = 1'b1; exp_c.id_exe_bubble = 1'b1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_error <= 1'b0; m_consec <= 0; m_stall <= 0; m_flush <= 0;
    end else begin
      if (!m_error && mem_req && !mem_ready) begin
        m_consec <= m_consec + 1;
        if (m_consec + 1 >= TO) m_error <= 1'b1;
      end else begin
        m_consec <= 0;
      end
      if (cnt_clear) m_stall <= 0;
      else if (exp_c.pc_freeze && m_stall < CMAX) m_stall <= m_stall + 1;
      if (cnt_clear) m_flush <= 0;
      else if (exp_c.if_id_flush && m_flush < CMAX) m_flush <= m_flush + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("pc_freeze", 16'(pc_freeze), 16'(exp_c.pc_freeze));
    check("if_id_freeze", 16'(if_id_freeze), 16'(exp_c.if_id_freeze));
    check("id_exe_bubble", 16'(id_exe_bubble), 16'(exp_c.id_exe_bubble));
    check("id_exe_freeze", 16'(id_exe_freeze), 16'(exp_c.id_exe_freeze));
    check("exe_mem_freeze", 16'(exe_mem_freeze), 16'(exp_c.exe_mem_freeze));
    check("mem_wb_bubble", 16'(mem_wb_bubble), 16'(exp_c.mem_wb_bubble));
    check("if_id_flush", 16'(if_id_flush), 16'(exp_c.if_id_flush));
    check("id_exe_flush", 16'(id_exe_flush), 16'(exp_c.id_exe_flush));
    check("mem_timeout", 16'(mem_timeout), 16'(m_error));
    check("stall_count", 16'(stall_count), 16'(m_stall));
    check("flush_count", 16'(flush_count), 16'(m_flush));
  end

  task automatic drive(input logic h, input logic b, input logic req, input logic rdy,
                       input logic clr);
    hazard_detected = h; branch_taken = b; mem_req = req; mem_ready = rdy; cnt_clear = clr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: outputs stay low even with a pending memory stall
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("rst_pc_freeze", 16'(pc_freeze), 16'd0);
    check("rst_mem_wb_bubble", 16'(mem_wb_bubble), 16'd0);
    check("rst_stall_count", 16'(stall_count), 16'd0);
    check("rst_mem_timeout", 16'(mem_timeout), 16'd0);
    tick(); tick();
    mem_req = 1'b0; rst = 1'b0;

    // Hazard only for two cycles
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hz_pc_freeze", 16'(pc_freeze), 16'd1);
    check("hz_id_exe_bubble", 16'(id_exe_bubble), 16'd1);
    tick();
    check("hz2_if_id_freeze", 16'(if_id_freeze), 16'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hz_stall_count", 16'(stall_count), 16'd2);
    check("hz_flush_count", 16'(flush_count), 16'd0);

    // Branch wins over hazard
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("br_if_id_flush", 16'(if_id_flush), 16'd1);
    check("br_pc_freeze", 16'(pc_freeze), 16'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("br_flush_count", 16'(flush_count), 16'd1);
    check("br_stall_count", 16'(stall_count), 16'd2);

    // Clear, then 3 memory wait cycles and a ready cycle carrying a branch
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("mw_exe_mem_freeze", 16'(exe_mem_freeze), 16'd1);
    check("mw_if_id_flush", 16'(if_id_flush), 16'd0);
    tick(); tick(); tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("mw_rdy_flush", 16'(id_exe_flush), 16'd1);
    check("mw_rdy_pc_freeze", 16'(pc_freeze), 16'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mw_stall_count", 16'(stall_count), 16'd3);
    check("mw_flush_count", 16'(flush_count), 16'd1);
    check("mw_run_no_freeze", 16'(pc_freeze), 16'd0);
    tick();

    // Watchdog: ERROR after 4 stalled cycles, sticky afterwards
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    check("to_not_yet", 16'(mem_timeout), 16'd0);
    tick();
    check("to_set", 16'(mem_timeout), 16'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("to_sticky", 16'(mem_timeout), 16'd1);
    check("to_pc_freeze", 16'(pc_freeze), 16'd1);
    check("to_no_flush", 16'(if_id_flush), 16'd0);
    tick(); tick();
    check("to_stall_count", 16'(stall_count), 16'd6);

    // Leave ERROR, then reset asynchronously in the second MEM_WAIT cycle
    rst = 1'b1; #2; rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("rmw_pc_freeze", 16'(pc_freeze), 16'd0);
    check("rmw_mem_wb_bubble", 16'(mem_wb_bubble), 16'd0);
    check("rmw_stall_count", 16'(stall_count), 16'd0);
    tick();
    mem_req = 1'b0; rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rmw_after_freeze", 16'(pc_freeze), 16'd0);
    tick();
    check("rmw_after_count", 16'(stall_count), 16'd0);

    // Saturation and clear-over-increment
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("sat_stall_count", 16'(stall_count), 16'd15);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check("clr_stall_count", 16'(stall_count), 16'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
